// File: rtl/pixel_readout_if.sv
// pixel_readout_if: ready/valid pixel stream from the readout FIFO to its sink.
interface pixel_readout_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
);
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  modport master (output out_data, out_index, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_index, out_last, out_valid, output out_ready);
endinterface

// File: rtl/pixel_readout.sv
// pixel_readout: single-slope ramp ADC per pixel with optional CDS, streamed out via a ready/valid FIFO.
// Define PIXEL_READOUT_SATURATE_EN to clamp negative CDS results to 0 instead of wrapping.
module pixel_readout #(
  parameter int PIXEL_COUNT = 4,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  localparam int IDX_W      = $clog2(PIXEL_COUNT),
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   erase,
  input  logic                   corr,
  input  logic                   expose,
  input  logic                   convert,
  input  logic                   read,
  input  logic                   idle,
  input  logic [IDX_W-1:0]       pixel_select,
  input  logic [PIXEL_COUNT-1:0] cmp,
  pixel_readout_if.master        px,
  output logic                   overflow,
  output logic                   busy
);
  typedef enum logic [2:0] {IDLE, ARMED, CONV_RST, WAIT_EXP, CONV_SIG, READOUT} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_ramp;
  logic [DATA_W-1:0] r_rst [PIXEL_COUNT];
  logic [DATA_W-1:0] r_sig [PIXEL_COUNT];
  logic [PIXEL_COUNT-1:0] r_done;
  logic r_cds, r_erase_d, r_act_d, r_bank_sig, r_ovf;
  logic w_conv_rst, w_conv_sig, w_push, w_fill;
  logic [DATA_W-1:0] w_cds_val, w_val;
  logic [AW:0] r_wr, r_rd;
  logic [DATA_W-1:0] r_mem_val [FIFO_DEPTH];
  logic [IDX_W-1:0]  r_mem_idx [FIFO_DEPTH];
  logic w_empty, w_full, w_pop, w_wr_en;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARMED:    w_next = convert ? (r_cds ? CONV_RST : CONV_SIG) : expose ? WAIT_EXP : ARMED;
      CONV_RST: w_next = convert ? CONV_RST : WAIT_EXP;
      WAIT_EXP: w_next = convert ? CONV_SIG : WAIT_EXP;
      CONV_SIG: w_next = read ? READOUT : CONV_SIG;
      READOUT:  w_next = read ? READOUT : IDLE;
      default:  w_next = IDLE;
    endcase
    if (idle && r_state != ARMED) w_next = IDLE;
    if (erase) w_next = ARMED;
  end
  // The first convert cycle is still seen in ARMED/WAIT_EXP, so the bank is chosen from the phase.
  always_comb begin
    busy       = r_state != IDLE;
    w_conv_rst = convert && !erase && (r_state == CONV_RST || (r_state == ARMED && r_cds));
    w_conv_sig = convert && !erase && (r_state == CONV_SIG || r_state == WAIT_EXP || (r_state == ARMED && !r_cds));
    w_push     = read && (r_state == CONV_SIG || r_state == READOUT);
  end
  assign w_fill = r_act_d && !convert;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ramp     <= '0;
      r_done     <= '0;
      r_cds      <= 1'b0;
      r_erase_d  <= 1'b0;
      r_act_d    <= 1'b0;
      r_bank_sig <= 1'b0;
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        r_rst[i] <= '0;
        r_sig[i] <= '0;
      end
    end else begin
      r_erase_d  <= erase;
      r_ramp     <= !convert ? '0 : (&r_ramp) ? r_ramp : r_ramp + 1'b1;
      r_act_d    <= w_conv_rst | w_conv_sig;
      r_bank_sig <= w_conv_sig;
      if (erase) r_cds <= (r_erase_d & r_cds) | corr;
      for (int i = 0; i < PIXEL_COUNT; i++)
        if (erase) r_done[i] <= 1'b0;
        else if (w_fill) begin
          r_done[i] <= 1'b0;
          if (!r_done[i] && r_bank_sig) r_sig[i] <= '1;
          if (!r_done[i] && !r_bank_sig) r_rst[i] <= '1;
        end else if ((w_conv_rst | w_conv_sig) && cmp[i] && !r_done[i]) begin
          r_done[i] <= 1'b1;
          if (w_conv_sig) r_sig[i] <= r_ramp;
          else r_rst[i] <= r_ramp;
        end
    end
`ifdef PIXEL_READOUT_SATURATE_EN
  logic [DATA_W:0] w_diff;
  always_comb begin
    w_diff    = {1'b0, r_sig[pixel_select]} - {1'b0, r_rst[pixel_select]};
    w_cds_val = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
  end
`else
  assign w_cds_val = r_sig[pixel_select] - r_rst[pixel_select];
`endif
  assign w_val   = r_cds ? w_cds_val : r_sig[pixel_select];
  assign w_empty = r_wr == r_rd;
  assign w_full  = (r_wr - r_rd) == (AW+1)'(FIFO_DEPTH);
  assign w_pop   = !w_empty && px.out_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr_en) begin
      r_mem_val[r_wr[AW-1:0]] <= w_val;
      r_mem_idx[r_wr[AW-1:0]] <= pixel_select;
    end
  assign px.out_valid = !w_empty;
  assign px.out_data  = w_empty ? '0 : r_mem_val[r_rd[AW-1:0]];
  assign px.out_index = w_empty ? '0 : r_mem_idx[r_rd[AW-1:0]];
  assign px.out_last  = !w_empty && r_mem_idx[r_rd[AW-1:0]] == IDX_W'(PIXEL_COUNT-1);
  assign overflow     = r_ovf;
endmodule
